// File: rtl/light_sequencer_if.sv
// Signal bundle between the light sequencer and its surroundings
// (timebase, LFSR, player button, reaction timer). The master modport
// drives the inputs of the sequencer; the slave modport is the sequencer.
interface light_sequencer_if #(
  parameter int N_LEDS  = 10,
  parameter int DELAY_W = 14
);
  logic               tick;
  logic               trigger;
  logic [DELAY_W-1:0] delay_val;
  logic               react;
  logic               en_lfsr;
  logic [N_LEDS-1:0]  ledr;
  logic               busy;
  logic               lights_out;
  logic               jump_start;

  modport master (
    output tick, trigger, delay_val, react,
    input  en_lfsr, ledr, busy, lights_out, jump_start
  );

  modport slave (
    input  tick, trigger, delay_val, react,
    output en_lfsr, ledr, busy, lights_out, jump_start
  );
endinterface

// File: rtl/light_sequencer.sv
// Start-light sequencer: fills an N_LEDS bar from the MSB down, one light
// every STEP_TICKS ticks, holds all lights for delay_val+1 ticks, then
// blanks them with a one-cycle lights_out pulse.
// Optional jump-start detection: define LIGHT_SEQUENCER_JUMP_DETECT_EN.
module light_sequencer #(
  parameter int N_LEDS     = 10,
  parameter int STEP_TICKS = 1,
  parameter int DELAY_W    = 14
) (
  input logic             clk,
  input logic             rst,
  light_sequencer_if.slave bus
);

  localparam int                SC_W    = $clog2(STEP_TICKS) + 1;
  localparam logic [SC_W-1:0]   SC_LAST = SC_W'(STEP_TICKS - 1);
  localparam logic [N_LEDS-1:0] LED_MSB = N_LEDS'(1) << (N_LEDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [SC_W-1:0]    r_sc;
  logic [DELAY_W-1:0] r_dc;
  logic [N_LEDS-1:0]  r_ledr;
  logic               r_lights_out;
  logic               r_jump_start;

  logic [N_LEDS-1:0]  w_ledr_shift;
  logic               w_tick_step;
  logic               w_fill_done;
  logic               w_hold_expire;
  logic               w_react_fault;
  logic               w_en_lfsr;
  logic               w_busy;

  // Next bar pattern: one more light from the top. With a single light the
  // bar is already full, so the first step completes the fill.
  assign w_ledr_shift  = (r_ledr >> 1) | LED_MSB;
  assign w_tick_step   = bus.tick && (r_sc == SC_LAST);
  assign w_fill_done   = w_tick_step && (&w_ledr_shift);
  assign w_hold_expire = bus.tick && (r_dc == '0);

`ifdef LIGHT_SEQUENCER_JUMP_DETECT_EN
  assign w_react_fault = bus.react && ((r_state == S_FILL) || (r_state == S_HOLD));
`else
  // Without jump detection the button is not used by this block.
  logic w_unused_react;
  assign w_unused_react = bus.react;
  assign w_react_fault  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state decode; a button press outranks any tick event.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_state_nx
    // unassigned, which would infer a latch.
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (bus.trigger) w_state_nx = S_FILL;
      S_FILL: begin
        if (w_react_fault)    w_state_nx = S_FAULT;
        else if (w_fill_done) w_state_nx = S_HOLD;
      end
      S_HOLD: begin
        if (w_react_fault)      w_state_nx = S_FAULT;
        else if (w_hold_expire) w_state_nx = S_IDLE;
      end
`ifdef LIGHT_SEQUENCER_JUMP_DETECT_EN
      S_FAULT: if (bus.trigger) w_state_nx = S_IDLE;
`endif
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output decode: LFSR runs only while idle; busy covers the sequence proper.
  always_comb begin
    w_en_lfsr = (r_state == S_IDLE);
    w_busy    = (r_state == S_FILL) || (r_state == S_HOLD);
  end

  // Registered datapath: light bar, step/delay counters and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ledr       <= '0;
      r_sc         <= '0;
      r_dc         <= '0;
      r_lights_out <= 1'b0;
      r_jump_start <= 1'b0;
    end else begin
      r_lights_out <= 1'b0;
      r_jump_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.trigger) begin
            r_ledr <= LED_MSB;
            r_sc   <= '0;
          end else begin
            r_ledr <= '0;
          end
        end
        S_FILL: begin
          if (w_react_fault) begin
            r_ledr       <= '0;
            r_jump_start <= 1'b1;
          end else if (bus.tick) begin
            if (w_tick_step) begin
              r_sc   <= '0;
              r_ledr <= w_ledr_shift;
              // The delay is captured once, on entry to HOLD.
              if (&w_ledr_shift) r_dc <= bus.delay_val;
            end else begin
              r_sc <= r_sc + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (w_react_fault) begin
            r_ledr       <= '0;
            r_jump_start <= 1'b1;
          end else if (bus.tick) begin
            if (r_dc == '0) begin
              r_ledr       <= '0;
              r_lights_out <= 1'b1;
            end else begin
              r_dc <= r_dc - 1'b1;
            end
          end
        end
`ifdef LIGHT_SEQUENCER_JUMP_DETECT_EN
        S_FAULT: begin
          // Bar was cleared on entry, so the first tick shows all lights.
          if (bus.trigger)   r_ledr <= '0;
          else if (bus.tick) r_ledr <= ~r_ledr;
        end
`endif
        default: r_ledr <= '0;
      endcase
    end
  end

  assign bus.en_lfsr    = w_en_lfsr;
  assign bus.busy       = w_busy;
  assign bus.ledr       = r_ledr;
  assign bus.lights_out = r_lights_out;
  assign bus.jump_start = r_jump_start;

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: two instances (10 lights / 1 tick per step and
// 4 lights / 3 ticks per step) share one stimulus stream. A tick-count model
// predicts every output each cycle; directed checks pin key literal values.
// Honours LIGHT_SEQUENCER_JUMP_DETECT_EN the same way as the design.
module tb_light_sequencer;

`ifdef LIGHT_SEQUENCER_JUMP_DETECT_EN
  localparam bit JD = 1'b1;
`else
  localparam bit JD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        trigger = 1'b0;
  logic        react = 1'b0;
  logic [13:0] delay_val = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  light_sequencer_if #(.N_LEDS(10), .DELAY_W(14)) ia ();
  light_sequencer_if #(.N_LEDS(4),  .DELAY_W(14)) ib ();

  assign ia.tick = tick;       assign ib.tick = tick;
  assign ia.trigger = trigger; assign ib.trigger = trigger;
  assign ia.react = react;     assign ib.react = react;
  assign ia.delay_val = delay_val;
  assign ib.delay_val = delay_val;

  light_sequencer #(.N_LEDS(10), .STEP_TICKS(1), .DELAY_W(14)) dut_a (
    .clk(clk), .rst(rst), .bus(ia.slave));
  light_sequencer #(.N_LEDS(4), .STEP_TICKS(3), .DELAY_W(14)) dut_b (
    .clk(clk), .rst(rst), .bus(ib.slave));

  task automatic check(input string name, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h, want %0h", name, d, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode 0 idle, 1 running (fill+hold), 2 fault. While running, t counts
  // ticks since the trigger; the bar and expiry follow from t arithmetically.
  int          n_l[2] = '{10, 4};
  int          st[2]  = '{1, 3};
  int          mode[2] = '{0, 0};
  int          t[2]    = '{0, 0};
  int          hl[2]   = '{0, 0};
  logic [9:0]  fled[2] = '{10'h0, 10'h0};
  bit          lo_e[2] = '{1'b0, 1'b0};
  bit          js_e[2] = '{1'b0, 1'b0};

  function automatic int mask(input int d);
    return (1 << n_l[d]) - 1;
  endfunction

  function automatic int t_hold(input int d);
    return ((n_l[d] > 1) ? (n_l[d] - 1) : 1) * st[d];
  endfunction

  function automatic logic [9:0] m_ledr(input int d);
    int lit;
    if (mode[d] == 0) return 10'h0;
    if (mode[d] == 2) return fled[d];
    lit = t[d] / st[d] + 1;
    if (lit > n_l[d]) lit = n_l[d];
    return 10'(((1 << lit) - 1) << (n_l[d] - lit));
  endfunction

  task automatic m_update(input int d);
    lo_e[d] = 1'b0;
    js_e[d] = 1'b0;
    case (mode[d])
      0: if (trigger) begin mode[d] = 1; t[d] = 0; end
      1: begin
        if (react && JD) begin
          mode[d] = 2; fled[d] = 10'h0; js_e[d] = 1'b1;
        end else if (tick) begin
          t[d]++;
          if (t[d] == t_hold(d)) hl[d] = int'(delay_val);
          else if (t[d] > t_hold(d) && t[d] == t_hold(d) + hl[d] + 1) begin
            mode[d] = 0; lo_e[d] = 1'b1;
          end
        end
      end
      default: begin
        if (trigger) mode[d] = 0;
        else if (tick) fled[d] = 10'(~fled[d] & 10'(mask(d)));
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mode[d] = 0; t[d] = 0; lo_e[d] = 1'b0; js_e[d] = 1'b0; fled[d] = 10'h0;
      end else begin
        m_update(d);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("m_ledr",    0, 32'(ia.ledr),       32'(m_ledr(0)));
    check("m_en_lfsr", 0, 32'(ia.en_lfsr),    32'(mode[0] == 0));
    check("m_busy",    0, 32'(ia.busy),       32'(mode[0] == 1));
    check("m_lo",      0, 32'(ia.lights_out), 32'(lo_e[0]));
    check("m_js",      0, 32'(ia.jump_start), 32'(js_e[0]));
    check("m_ledr",    1, 32'(ib.ledr),       32'(m_ledr(1)));
    check("m_en_lfsr", 1, 32'(ib.en_lfsr),    32'(mode[1] == 0));
    check("m_busy",    1, 32'(ib.busy),       32'(mode[1] == 1));
    check("m_lo",      1, 32'(ib.lights_out), 32'(lo_e[1]));
    check("m_js",      1, 32'(ib.jump_start), 32'(js_e[1]));
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  // All input changes happen 1 time unit after a falling edge.
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Apply one tick; returns positioned just after the edge that used it.
  task automatic tick_edge();
    tick = 1'b1; cyc(1); tick = 1'b0;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1; cyc(1); trigger = 1'b0;
  endtask

  // Tick until dut d pulses lights_out; n = ticks used. Leaves the bench in
  // the pulse cycle.
  task automatic tick_until_out(input int d, input int max, output int n);
    bit found;
    n = 0; found = 1'b0;
    while (!found && n < max) begin
      if (n > 0) cyc(1);
      tick_edge();
      n++;
      found = (d == 0) ? ia.lights_out : ib.lights_out;
    end
    check("lights_out_seen", d, 32'(found), 32'd1);
  endtask

  logic [9:0] fill_a[10] = '{10'h200, 10'h300, 10'h380, 10'h3C0, 10'h3E0,
                            10'h3F0, 10'h3F8, 10'h3FC, 10'h3FE, 10'h3FF};
  logic [3:0] fill_b[9]  = '{4'h8, 4'h8, 4'hC, 4'hC, 4'hC, 4'hE, 4'hE, 4'hE, 4'hF};

  initial begin
    int n;
    cyc(2);
    check("rst_ledr",    0, 32'(ia.ledr),    32'h0);
    check("rst_en_lfsr", 0, 32'(ia.en_lfsr), 32'd1);
    check("rst_busy",    0, 32'(ia.busy),    32'd0);
    rst = 1'b0;
    cyc(2);

    // Basic sequence, delay 5.
    delay_val = 14'd5;
    pulse_trigger();
    check("first_light", 0, 32'(ia.ledr),    32'(fill_a[0]));
    check("fill_en",     0, 32'(ia.en_lfsr), 32'd0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1); tick_edge();
      check("fill_a", 0, 32'(ia.ledr), 32'(fill_a[k]));
    end
    for (int k = 1; k <= 5; k++) begin
      cyc(1); tick_edge();
      check("hold_lo", 0, 32'(ia.lights_out), 32'd0);
      check("hold_ledr", 0, 32'(ia.ledr), 32'h3FF);
    end
    cyc(1); tick_edge();
    check("out_pulse",   0, 32'(ia.lights_out), 32'd1);
    check("out_ledr",    0, 32'(ia.ledr),       32'h0);
    check("out_en_lfsr", 0, 32'(ia.en_lfsr),    32'd1);
    react = 1'b1; cyc(1); react = 1'b0;
    check("out_pulse_end", 0, 32'(ia.lights_out), 32'd0);
    check("idle_react_js", 0, 32'(ia.jump_start), 32'd0);
    check("idle_react_en", 0, 32'(ia.en_lfsr),    32'd1);
    cyc(2);

    // 4 lights, 3 ticks per step, delay 0.
    delay_val = 14'd0;
    pulse_trigger();
    check("b_first", 1, 32'(ib.ledr), 32'h8);
    for (int k = 0; k < 9; k++) begin
      cyc(1); tick_edge();
      check("fill_b", 1, 32'(ib.ledr), 32'(fill_b[k]));
    end
    cyc(1); tick_edge();
    check("b_out_pulse", 1, 32'(ib.lights_out), 32'd1);
    check("b_out_ledr",  1, 32'(ib.ledr),       32'h0);
    cyc(2);

    // Reset in the middle of HOLD.
    delay_val = 14'd20;
    pulse_trigger();
    for (int k = 0; k < 9; k++) begin cyc(1); tick_edge(); end
    check("pre_rst_ledr", 0, 32'(ia.ledr), 32'h3FF);
    rst = 1'b1; #1;
    check("rst_hold_ledr", 0, 32'(ia.ledr),       32'h0);
    check("rst_hold_en",   0, 32'(ia.en_lfsr),    32'd1);
    check("rst_hold_lo",   0, 32'(ia.lights_out), 32'd0);
    cyc(1); rst = 1'b0; cyc(1);
    pulse_trigger();
    check("restart_ledr", 0, 32'(ia.ledr), 32'h200);
    tick_until_out(0, 40, n);
    check("restart_ticks", 0, 32'(n), 32'd30);
    cyc(2);

    // Delay changed during HOLD, trigger held high throughout.
    delay_val = 14'd3;
    trigger = 1'b1;
    cyc(1);
    for (int k = 0; k < 9; k++) begin cyc(1); tick_edge(); end
    check("held_full", 0, 32'(ia.ledr), 32'h3FF);
    delay_val = 14'd50;
    cyc(1);
    tick_until_out(0, 20, n);
    check("latched_hold", 0, 32'(n), 32'd4);
    check("pulse_busy",   0, 32'(ia.busy), 32'd0);
    delay_val = 14'd1;
    cyc(1);
    check("retrigger", 0, 32'(ia.ledr), 32'h200);
    trigger = 1'b0;
    cyc(1);
    tick_until_out(0, 20, n);
    check("retrig_ticks", 0, 32'(n), 32'd11);
    cyc(2);

    // React on the HOLD-expiry tick.
    delay_val = 14'd2;
    pulse_trigger();
    for (int k = 0; k < 11; k++) begin cyc(1); tick_edge(); end
    cyc(1);
    tick = 1'b1; react = 1'b1; cyc(1); tick = 1'b0; react = 1'b0;
`ifdef LIGHT_SEQUENCER_JUMP_DETECT_EN
    check("exp_js",   0, 32'(ia.jump_start), 32'd1);
    check("exp_lo",   0, 32'(ia.lights_out), 32'd0);
    check("exp_ledr", 0, 32'(ia.ledr),       32'h0);
    check("exp_en",   0, 32'(ia.en_lfsr),    32'd0);
    check("exp_busy", 0, 32'(ia.busy),       32'd0);
    cyc(1); tick_edge();
    check("fault_on",  0, 32'(ia.ledr), 32'h3FF);
    cyc(1); tick_edge();
    check("fault_off", 0, 32'(ia.ledr), 32'h0);
    pulse_trigger();
    check("fault_exit_en", 0, 32'(ia.en_lfsr), 32'd1);
`else
    check("exp_lo",   0, 32'(ia.lights_out), 32'd1);
    check("exp_js",   0, 32'(ia.jump_start), 32'd0);
    check("exp_ledr", 0, 32'(ia.ledr),       32'h0);
`endif
    cyc(2);

    // React during FILL at 0x380.
    delay_val = 14'd1;
    pulse_trigger();
    for (int k = 0; k < 2; k++) begin cyc(1); tick_edge(); end
    check("fill_380", 0, 32'(ia.ledr), 32'h380);
    cyc(1);
    react = 1'b1; cyc(1); react = 1'b0;
`ifdef LIGHT_SEQUENCER_JUMP_DETECT_EN
    check("js_pulse", 0, 32'(ia.jump_start), 32'd1);
    check("js_ledr",  0, 32'(ia.ledr),       32'h0);
    check("js_busy",  0, 32'(ia.busy),       32'd0);
    cyc(1);
    check("js_end", 0, 32'(ia.jump_start), 32'd0);
    tick_edge();
    check("tog1", 0, 32'(ia.ledr), 32'h3FF);
    cyc(1); tick_edge();
    check("tog2", 0, 32'(ia.ledr), 32'h0);
    cyc(1); tick_edge();
    check("tog3", 0, 32'(ia.ledr), 32'h3FF);
    check("b_tog", 1, 32'(ib.ledr), 32'hF);
    pulse_trigger();
    check("fault_idle_ledr", 0, 32'(ia.ledr),    32'h0);
    check("fault_idle_en",   0, 32'(ia.en_lfsr), 32'd1);
`else
    check("no_js",      0, 32'(ia.jump_start), 32'd0);
    check("no_js_ledr", 0, 32'(ia.ledr),       32'h380);
    tick_until_out(0, 20, n);
    check("no_js_ticks", 0, 32'(n), 32'd9);
`endif
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/light_sequencer.md
# light_sequencer

Parametrised start-light sequencer for the reaction-timer design. On trigger it fills an N-wide LED bar from the MSB down, one light every STEP_TICKS ticks. It then holds all lights for a random delay taken from the LFSR and extinguishes them with a one-cycle `lights_out` pulse to the reaction timer. It runs on the system clock with `tick` as an enable, counts the random delay internally, and optionally detects jump starts.

## Interface
- `N_LEDS`, default 10: number of lights; must be >= 1.
- `STEP_TICKS`, default 1: ticks between successive lights; must be >= 1.
- `DELAY_W`, default 14: width of the random delay value.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-`clk`-wide timebase strobe (e.g. 1 ms).
- `trigger`  in  1  start request, level-sampled.
- `delay_val`  in  DELAY_W  random delay in ticks, from the LFSR.
- `react`  in  1  player button, already synchronised and debounced.
- `en_lfsr`  out  1  high in IDLE; requests the LFSR to keep running.
- `ledr`  out  N_LEDS  light bar; bit N_LEDS-1 lights first.
- `busy`  out  1  high in FILL and HOLD.
- `lights_out`  out  1  one-cycle pulse when the lights go out.
- `jump_start`  out  1  one-cycle pulse on jump-start detection.

## Operation
- States: IDLE, FILL, HOLD, plus FAULT when JUMP_DETECT_EN is defined.
- Counters:
  - step counter `sc`, width clog2(STEP_TICKS)+1;
  - delay counter `dc`, width DELAY_W.
- IDLE:
  - `ledr`=0, `en_lfsr`=1, `busy`=0.
  - `trigger`=1 moves to FILL, sets `ledr`=1 in MSB only, clears `sc`.
- FILL:
  - On each `tick`, `sc` increments.
  - When `tick` arrives with `sc`==STEP_TICKS-1, `sc` clears and `ledr` shifts right with a 1 inserted at the MSB.
  - On the edge where `ledr` becomes all ones, load `dc`<=`delay_val` and move to HOLD.
  - With N_LEDS=1, FILL moves to HOLD on the first step.
- HOLD:
  - `ledr` is all ones.
  - On each `tick`: if `dc`==0, clear `ledr`, pulse `lights_out`, and go to IDLE; otherwise `dc` decrements.
  - Hold time is therefore `delay_val`+1 ticks; `delay_val`=0 means lights go out on the first tick.
- `trigger` is ignored outside IDLE; a retrigger requires IDLE.
- `en_lfsr`=(state==IDLE) and `busy`=(state is FILL or HOLD) are combinational decodes.
- `ledr`, `lights_out` and `jump_start` are registered.
- `delay_val` is sampled only on the FILL-to-HOLD edge; later changes have no effect.
- Unreachable state encodings recover to IDLE with `ledr`=0.

## Timing
- Reset (asynchronous, any state): state=IDLE, `ledr`=0, `sc`=0, `dc`=0, `lights_out`=0, `jump_start`=0; hence `en_lfsr`=1 and `busy`=0.
- Latency from trigger to first light: one cycle. `trigger` is sampled at edge k; `ledr[N_LEDS-1]`=1 from edge k.
- Light i (counting from 0 at the MSB) is lit i*STEP_TICKS ticks after the first light.
- HOLD lasts exactly `delay_val`+1 ticks after the last light is lit.
- `lights_out` is high for exactly the one cycle after the edge that clears `ledr`; the state is IDLE in that same cycle.
- Priority within a cycle is `rst` > `react` (fault) > `tick` step/expiry.
- `react` and the HOLD-expiry tick in the same cycle: FAULT wins and no `lights_out` is pulsed.
- `react` in IDLE never causes a fault, including the cycle in which `lights_out` is high.

## Configuration
- Macro `LIGHT_SEQUENCER_JUMP_DETECT_EN`.
- Defined:
  - `react`=1 in FILL or HOLD clears `ledr`, pulses `jump_start` for one cycle, and enters FAULT.
  - In FAULT, `ledr` starts all ones and inverts on every `tick`; `busy`=0 and `en_lfsr`=0.
  - `trigger`=1 in FAULT moves to IDLE with `ledr`=0. A new sequence needs a further trigger.
- Undefined:
  - FAULT does not exist.
  - `react` is ignored and `jump_start` is tied to 0.

## Test plan
- Basic sequence, N_LEDS=10, STEP_TICKS=1, `delay_val`=5, trigger once:
  - `ledr` goes 0x200, 0x300, ... 0x3FF on successive ticks;
  - lights go out 6 ticks later with a single-cycle `lights_out`;
  - `en_lfsr` is 0 throughout and returns to 1.
- STEP_TICKS=3, N_LEDS=4, `delay_val`=0:
  - each new light appears after exactly 3 ticks;
  - lights go out on the first tick in HOLD.
- Assert `rst` mid-HOLD with `ledr`=0x3FF: `ledr`=0, `en_lfsr`=1, no `lights_out` in that cycle; a subsequent trigger restarts cleanly.
- Change `delay_val` during HOLD and hold `trigger` high throughout a sequence: the hold time follows the value latched at HOLD entry; no restart occurs before IDLE.
- With the macro defined, pulse `react` during FILL at `ledr`=0x380:
  - one-cycle `jump_start`, then `ledr` toggles 0x3FF/0x000 on each tick;
  - `trigger` returns to IDLE.
- With the macro defined, drive `react` on the HOLD-expiry tick: FAULT is entered and `lights_out` stays 0. The same stimulus without the macro gives a normal `lights_out`.
